// File: rtl/ser2par_deser.sv
`default_nettype none
// ============================================================================
// Module   : ser2par_deser
// Purpose  : Serial-to-parallel deserializer. It packs WIDTH-bit words and
//            holds them in a one-word valid/ready buffer. It flags framing
//            (sync) errors and dropped words (overrun).
// Revision : 1.0 - initial release
// ============================================================================
module ser2par_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_in,
  input  logic                       s_valid,
  input  logic                       s_first,
  output logic [WIDTH-1:0]           p_data,
  output logic                       p_valid,
  input  logic                       p_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       sync_err,
  output logic                       overrun
);

  localparam int c_CNT_W = $clog2(WIDTH+1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_shift, w_shift_nxt;
  logic [WIDTH-1:0]   w_word;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [c_CNT_W-1:0] w_idx;
  logic [WIDTH-1:0]   r_pdata, w_pdata_nxt;
  logic               r_pvalid, w_pvalid_nxt;
  logic               r_sync_err, w_sync_nxt;
  logic               r_overrun, w_overrun_nxt;
  logic               w_restart;
  logic               w_complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_pdata    <= '0;
      r_pvalid   <= 1'b0;
      r_sync_err <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pdata    <= w_pdata_nxt;
      r_pvalid   <= w_pvalid_nxt;
      r_sync_err <= w_sync_nxt;
      r_overrun  <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_pdata_nxt   = r_pdata;
    w_pvalid_nxt  = r_pvalid;
    w_overrun_nxt = r_overrun;
    w_sync_nxt    = 1'b0;
    w_complete    = 1'b0;

    // A bit accepted in IDLE, or with s_first, starts a fresh word at position 0.
    w_restart = (r_state == IDLE) || s_first;
    w_idx     = w_restart ? '0 : r_cnt;
    w_word    = w_restart ? '0 : r_shift;
    for (int i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST ? (i == WIDTH - 1 - int'(w_idx)) : (i == int'(w_idx)))
        w_word[i] = s_in;
    end

    if (s_valid) begin
      w_sync_nxt = s_first && (r_state == COLLECT);
      if (!w_restart && (r_cnt == c_CNT_W'(WIDTH - 1))) begin
        w_complete  = 1'b1;
        w_shift_nxt = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end else begin
        w_shift_nxt = w_word;
        w_cnt_nxt   = w_idx + 1'b1;
        w_state_nxt = COLLECT;
      end
    end

    // Holding register: a word consumed on this edge frees the slot for the new one.
    if (w_complete) begin
      if (!r_pvalid || p_ready) begin
        w_pdata_nxt  = w_word;
        w_pvalid_nxt = 1'b1;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end else if (r_pvalid && p_ready) begin
      w_pvalid_nxt = 1'b0;
    end
  end

  assign p_data   = r_pdata;
  assign p_valid  = r_pvalid;
  assign bit_cnt  = r_cnt;
  assign sync_err = r_sync_err;
  assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ser2par_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_ser2par_deser
// Purpose  : Self-checking bench for ser2par_deser. It drives MSB-first and
//            LSB-first instances from one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ser2par_deser;

  localparam int c_W = 8;

  logic clk = 1'b0;
  logic rst, s_in, s_valid, s_first, p_ready;
  logic [c_W-1:0] pd1, pd0;
  logic pv1, pv0, se1, se0, ov1, ov0;
  logic [3:0] bc1, bc0;

  always #5 clk = ~clk;

  ser2par_deser #(.WIDTH(c_W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .s_first(s_first),
    .p_data(pd1), .p_valid(pv1), .p_ready(p_ready), .bit_cnt(bc1),
    .sync_err(se1), .overrun(ov1));

  ser2par_deser #(.WIDTH(c_W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .s_first(s_first),
    .p_data(pd0), .p_valid(pv0), .p_ready(p_ready), .bit_cnt(bc0),
    .sync_err(se0), .overrun(ov0));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the bits of the current word in arrival order, plus a one-word output slot.
  bit        q_bits[$];
  bit        m_pv, m_se, m_ov;
  bit [7:0]  m_pd1, m_pd0;

  int cyc = 0;
  int pv_cycles[$];
  int se_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit v, input bit f, input bit d, input bit r, input bit rs);
    bit comp;
    int w1, w0;
    if (rs) begin
      q_bits.delete();
      m_pv = 0; m_se = 0; m_ov = 0; m_pd1 = 0; m_pd0 = 0;
      return;
    end
    comp = 0; w1 = 0; w0 = 0;
    m_se = 0;
    if (v) begin
      if (f && q_bits.size() > 0) begin
        m_se = 1;
        q_bits.delete();
      end
      q_bits.push_back(d);
      if (q_bits.size() == c_W) begin
        comp = 1;
        for (int k = 0; k < c_W; k++) begin
          w1 += int'(q_bits[k]) * (1 << (c_W - 1 - k));
          w0 += int'(q_bits[k]) * (1 << k);
        end
        q_bits.delete();
      end
    end
    if (comp) begin
      if (!m_pv || r) begin
        m_pv = 1; m_pd1 = 8'(w1); m_pd0 = 8'(w0);
      end else begin
        m_ov = 1;
      end
    end else if (m_pv && r) begin
      m_pv = 0;
    end
  endtask

  task automatic step(input bit v, input bit f, input bit d, input bit r, input bit rs);
    @(negedge clk);
    s_valid = v; s_first = f; s_in = d; p_ready = r; rst = rs;
    @(posedge clk);
    model_edge(v, f, d, r, rs);
    #1;
    cyc++;
    chk("msb p_valid", 32'(pv1), 32'(m_pv));
    chk("msb p_data", 32'(pd1), 32'(m_pd1));
    chk("msb bit_cnt", 32'(bc1), 32'(q_bits.size()));
    chk("msb sync_err", 32'(se1), 32'(m_se));
    chk("msb overrun", 32'(ov1), 32'(m_ov));
    chk("lsb p_valid", 32'(pv0), 32'(m_pv));
    chk("lsb p_data", 32'(pd0), 32'(m_pd0));
    chk("lsb bit_cnt", 32'(bc0), 32'(q_bits.size()));
    chk("lsb sync_err", 32'(se0), 32'(m_se));
    chk("lsb overrun", 32'(ov0), 32'(m_ov));
    if (pv1) pv_cycles.push_back(cyc);
    if (se1) se_pulses++;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit r);
    logic [7:0] bb;
    bb = b;
    for (int k = 0; k < c_W; k++) step(1, k == 0, bb[7-k], r, 0);
  endtask

  typedef struct {
    bit       v, f, d, r, rs;
    bit       exp_pv;
    bit [7:0] exp_pd1, exp_pd0;
    int       exp_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] stream;
    int t0;
    rst = 1; s_in = 0; s_valid = 0; s_first = 0; p_ready = 0;

    // Directed table: 1,1,0,0,0,0,0,1 -> 0xC1 (MSB first) / 0x83 (LSB first).
    stream = 8'b1100_0001;
    vecs[0] = '{v:0, f:0, d:0, r:1, rs:1, exp_pv:0, exp_pd1:8'h00, exp_pd0:8'h00, exp_cnt:0};
    for (int k = 0; k < 8; k++)
      vecs[k+1] = '{v:1, f:(k == 0), d:stream[7-k], r:1, rs:0, exp_pv:(k == 7),
                    exp_pd1:(k == 7) ? 8'hC1 : 8'h00, exp_pd0:(k == 7) ? 8'h83 : 8'h00,
                    exp_cnt:(k + 1) % 8};
    vecs[9] = '{v:0, f:0, d:0, r:1, rs:0, exp_pv:0, exp_pd1:8'hC1, exp_pd0:8'h83, exp_cnt:0};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].v, vecs[i].f, vecs[i].d, vecs[i].r, vecs[i].rs);
      chk("tbl p_valid", 32'(pv1), 32'(vecs[i].exp_pv));
      chk("tbl msb data", 32'(pd1), 32'(vecs[i].exp_pd1));
      chk("tbl lsb data", 32'(pd0), 32'(vecs[i].exp_pd0));
      chk("tbl bit_cnt", 32'(bc0), 32'(vecs[i].exp_cnt));
      chk("tbl overrun", 32'(ov1), 32'h0);
      chk("tbl sync_err", 32'(se1), 32'h0);
    end

    // Overrun: two words with no consumer; the first word must be retained.
    send_byte(8'hC1, 0);
    send_byte(8'h3C, 0);
    chk("ovr held data", 32'(pd1), 32'hC1);
    chk("ovr sticky", 32'(ov1), 32'h1);
    step(0, 0, 0, 1, 0);
    chk("ovr drained", 32'(pv1), 32'h0);
    chk("ovr remains", 32'(ov1), 32'h1);
    step(0, 0, 0, 0, 1);

    // Back-to-back words with the consumer always ready.
    pv_cycles.delete();
    send_byte(8'hA5, 1);
    chk("b2b first data", 32'(pd1), 32'hA5);
    send_byte(8'h5A, 1);
    chk("b2b second data", 32'(pd1), 32'h5A);
    step(0, 0, 0, 1, 0);
    chk("b2b pulse count", 32'(pv_cycles.size()), 32'd2);
    if (pv_cycles.size() == 2) chk("b2b spacing", 32'(pv_cycles[1] - pv_cycles[0]), 32'd8);
    chk("b2b overrun", 32'(ov1), 32'h0);

    // Resync: 3 stray bits, then s_first restarts the word.
    se_pulses = 0;
    step(1, 1, 1, 1, 0); step(1, 0, 1, 1, 0); step(1, 0, 1, 1, 0);
    send_byte(8'hB4, 1);
    chk("sync data", 32'(pd1), 32'hB4);
    chk("sync lsb data", 32'(pd0), 32'h2D);
    step(0, 0, 0, 1, 0);
    chk("sync pulses", 32'(se_pulses), 32'd1);

    // Reset with a held word, an overrun, and a partial word pending.
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    for (int k = 0; k < 5; k++) step(1, k == 0, 1'(k & 1), 0, 0);
    step(1, 0, 1, 1, 1);
    chk("rst bit_cnt", 32'(bc1), 32'h0);
    chk("rst p_valid", 32'(pv1), 32'h0);
    chk("rst overrun", 32'(ov1), 32'h0);
    send_byte(8'hFF, 1);
    chk("post rst data", 32'(pd1), 32'hFF);
    chk("post rst valid", 32'(pv1), 32'h1);

    // Random traffic against the model.
    t0 = cyc;
    while (cyc - t0 < 3000) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 1'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
